// File: rtl/updown_seq_ctrl.sv
// Sequencer that drives the Up/Down pins of a TFF up/down counter from GOTO/SWEEP/STOP commands.
// Latency: an accepted command changes state at the accepting edge; up/down follow count combinationally.
// Backpressure: cmd_ready stays high once out of reset; every accepted command preempts the current one.
module updown_seq_ctrl #(
  parameter int W      = 4,
  parameter int DWELL  = 2,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [W-1:0]      cmd_lo,
  input  logic [W-1:0]      cmd_hi,
  input  logic [W-1:0]      count,
  output logic              up,
  output logic              down,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] passes
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DWELL, S_DONE} state_t;
  typedef enum logic {M_GOTO, M_SWEEP} mode_t;

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_GOTO  = 2'b01;
  localparam logic [1:0] CMD_SWEEP = 2'b10;

  // Dwell counter only needs to hold DWELL-1; keep at least one bit so DWELL=0/1 still elaborate.
  localparam int             DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DLOAD = DCW'((DWELL > 0) ? DWELL - 1 : 0);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [W-1:0]      dest_q, dest_d;
  logic [W-1:0]      lo_q, lo_d;
  logic [W-1:0]      hi_q, hi_d;
  logic [DCW-1:0]    dwell_q, dwell_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdy_q;

  logic              accept;
  logic              cmd_ok;
  logic              at_dest;
  logic [W-1:0]      dest_flip;

  assign accept    = cmd_valid & rdy_q;
  // Mode 11 and an empty/inverted sweep window are the only rejected commands.
  assign cmd_ok    = (cmd_mode == CMD_STOP) || (cmd_mode == CMD_GOTO) ||
                     ((cmd_mode == CMD_SWEEP) && (cmd_lo < cmd_hi));
  assign at_dest   = (count == dest_q);
  assign dest_flip = (dest_q == hi_q) ? lo_q : hi_q;

  // Direction comes straight from the live count, so motion stops the cycle count reaches dest.
  assign up        = (state_q == S_MOVE) && (count < dest_q);
  assign down      = (state_q == S_MOVE) && (count > dest_q);
  assign busy      = (state_q == S_MOVE) || (state_q == S_DWELL);
  assign done      = done_q;
  assign err       = err_q;
  assign passes    = passes_q;
  assign cmd_ready = rdy_q;

  // Next-state: a valid accepted command wins; otherwise the current motion progresses.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dest_d   = dest_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dwell_d  = dwell_q;
    passes_d = passes_q;
    done_d   = 1'b0;
    err_d    = accept && !cmd_ok;

    if (accept && cmd_ok) begin
      case (cmd_mode)
        CMD_GOTO: begin
          mode_d = M_GOTO;
          dest_d = cmd_hi;
          if (count == cmd_hi) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_MOVE;
          end
        end
        CMD_SWEEP: begin
          mode_d   = M_SWEEP;
          lo_d     = cmd_lo;
          hi_d     = cmd_hi;
          dest_d   = cmd_lo;
          passes_d = '0;
          state_d  = S_MOVE;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_MOVE: begin
          if (at_dest) begin
            if (mode_q == M_GOTO) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              if (dest_q == hi_q) begin
                passes_d = passes_q + 1'b1;
              end
              if (DWELL > 0) begin
                state_d = S_DWELL;
                dwell_d = DLOAD;
              end else begin
                dest_d = dest_flip;
              end
            end
          end
        end
        S_DWELL: begin
          if (dwell_q == '0) begin
            dest_d  = dest_flip;
            state_d = S_MOVE;
          end else begin
            dwell_d = dwell_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; cmd_ready rises on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= M_GOTO;
      dest_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      dwell_q  <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dest_q   <= dest_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dwell_q  <= dwell_d;
      passes_q <= passes_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Bench for updown_seq_ctrl: counter model in the loop, behavioural reference, per-cycle scoreboard.
// Stimulus is applied 1 time unit after each rising edge; the model runs 2 units after the edge.
// The monitor pops one expected record per cycle on the falling edge and compares every output.
module tb_updown_seq_ctrl;

  localparam int W      = 4;
  localparam int DWELL  = 2;
  localparam int PASS_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = 2'b00;
  logic [W-1:0]      cmd_lo = '0;
  logic [W-1:0]      cmd_hi = '0;
  logic [W-1:0]      count;
  logic              up, down, busy, done, err;
  logic [PASS_W-1:0] passes;

  updown_seq_ctrl #(.W(W), .DWELL(DWELL), .PASS_W(PASS_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .count(count),
    .up(up), .down(down), .busy(busy), .done(done), .err(err), .passes(passes)
  );

  always #5 clk = ~clk;

  // The TFF up/down counter the sequencer controls (Up has priority).
  always @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (up)   count <= count + 1'b1;
    else if (down) count <= count - 1'b1;
  end

  typedef struct packed {
    logic              rdy, up, down, busy, done, err;
    logic [W-1:0]      cnt;
    logic [PASS_W-1:0] passes;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   run_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Reference model: what the controller is doing, expressed as an activity plus a target.
  typedef enum int {A_IDLE, A_GOING, A_HOLDING, A_ARRIVED} act_t;
  act_t              m_act;
  bit                m_sweep, m_done, m_err, m_ready;
  logic [W-1:0]      m_tgt, m_lo, m_hi, m_count;
  logic [PASS_W-1:0] m_passes;
  int                m_hold_left;

  task automatic model_cycle();
    exp_t e;
    bit   mu, md, acc;
    if (!reset) begin
      m_act = A_IDLE; m_sweep = 0; m_done = 0; m_err = 0; m_ready = 0;
      m_tgt = '0; m_lo = '0; m_hi = '0; m_count = '0; m_passes = '0; m_hold_left = 0;
    end
    mu = (m_act == A_GOING) && (m_count < m_tgt);
    md = (m_act == A_GOING) && (m_count > m_tgt);
    e.rdy = m_ready; e.up = mu; e.down = md;
    e.busy = (m_act == A_GOING) || (m_act == A_HOLDING);
    e.done = m_done; e.err = m_err; e.cnt = m_count; e.passes = m_passes;
    exp_q.push_back(e);
    if (!reset) return;

    acc = cmd_valid && m_ready;
    m_done = 0;
    m_err = 0;
    if (acc && cmd_mode == 2'd0) begin
      m_act = A_IDLE;
    end else if (acc && cmd_mode == 2'd1) begin
      m_sweep = 0;
      m_tgt = cmd_hi;
      if (m_count == cmd_hi) begin m_act = A_ARRIVED; m_done = 1; end
      else m_act = A_GOING;
    end else if (acc && cmd_mode == 2'd2 && cmd_lo < cmd_hi) begin
      m_sweep = 1; m_lo = cmd_lo; m_hi = cmd_hi; m_tgt = cmd_lo;
      m_passes = '0; m_act = A_GOING;
    end else begin
      if (acc) m_err = 1;
      if (m_act == A_GOING && m_count == m_tgt) begin
        if (!m_sweep) begin
          m_act = A_ARRIVED; m_done = 1;
        end else begin
          if (m_tgt == m_hi) m_passes = m_passes + 8'd1;
          if (DWELL == 0) m_tgt = (m_tgt == m_hi) ? m_lo : m_hi;
          else begin m_act = A_HOLDING; m_hold_left = DWELL; end
        end
      end else if (m_act == A_HOLDING) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_tgt = (m_tgt == m_hi) ? m_lo : m_hi;
          m_act = A_GOING;
        end
      end
    end
    m_ready = 1;
    if (mu)      m_count = m_count + 4'd1;
    else if (md) m_count = m_count - 4'd1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (run_model) model_cycle();
    end
  end

  // Monitor: compares the DUT against the oldest expected record each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (run_model) begin
        chk("up_down_exclusive", 32'(up & down), 32'd0);
        if (exp_q.size() == 0) begin
          chk("scoreboard_has_entry", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
          chk("up",        32'(up),        32'(e.up));
          chk("down",      32'(down),      32'(e.down));
          chk("busy",      32'(busy),      32'(e.busy));
          chk("done",      32'(done),      32'(e.done));
          chk("err",       32'(err),       32'(e.err));
          chk("count",     32'(count),     32'(e.cnt));
          chk("passes",    32'(passes),    32'(e.passes));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [1:0] mode, input logic [W-1:0] lo, input logic [W-1:0] hi);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_lo = lo; cmd_hi = hi;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("reset_up_immediate",   32'(up),   32'd0);
    chk("reset_down_immediate", 32'(down), 32'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    run_model = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(3);

    // Directed: GOTO up, GOTO down, repeated GOTO, sweep, STOP while rising.
    send(2'd1, 4'd0, 4'd9);  idle(14);
    send(2'd1, 4'd0, 4'd2);  idle(12);
    send(2'd1, 4'd0, 4'd2);  idle(3);
    send(2'd2, 4'd3, 4'd6);  idle(40);
    n = 0;
    while (!(count == 4'd4 && up) && n < 60) begin
      tick();
      n++;
    end
    chk("wait_sweep_rising_at_4", 32'(n < 60), 32'd1);
    send(2'd0, 4'd0, 4'd0);  idle(5);

    // Rejected commands while idle and while moving.
    send(2'd2, 4'd7, 4'd7);  idle(2);
    send(2'd3, 4'd0, 4'd0);  idle(2);
    send(2'd1, 4'd0, 4'd15); idle(3);
    send(2'd2, 4'd7, 4'd7);  idle(2);
    send(2'd3, 4'd1, 4'd9);  idle(15);

    // Reset while moving down, then confirm nothing moves until a new command.
    send(2'd1, 4'd0, 4'd0);  idle(4);
    pulse_reset();
    idle(6);

    // Randomised command stream with occasional resets and back-to-back commands.
    for (int i = 0; i < 120; i++) begin
      int r;
      logic [1:0] mode;
      r = int'($urandom_range(0, 9));
      if (r == 0)      mode = 2'd0;
      else if (r <= 4) mode = 2'd1;
      else if (r <= 8) mode = 2'd2;
      else             mode = 2'd3;
      send(mode, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      idle(int'($urandom_range(0, 24)));
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end

    idle(3);
    run_model = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
